instr_fetch: RTL
================

# instr_fetch

Instruction fetch stage for the single-cycle MIPS core. It owns the program counter and fetches one word per instruction over a req/gnt/rvalid instruction-memory port. It holds the fetched word in an instruction register and presents its opcode and funct fields to the main decoder. When the downstream datapath accepts the instruction, it computes the next PC from the decoder's branch and jump controls and the ALU zero flag. It also keeps a retired-instruction counter.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned (bits [1:0] = 0).
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_n_i  input  1  synchronous active-low reset.
- imem_req_o  output  1  fetch request; held until granted.
- imem_addr_o32  output  32  fetch byte address; equals pc_o32.
- imem_gnt_i  input  1  request accepted this cycle.
- imem_rvalid_i  input  1  read data valid; at least 1 cycle after the grant.
- imem_rdata_i32  input  32  fetched instruction word.
- instr_valid_o  output  1  instruction register holds a valid word.
- instr_ready_i  input  1  datapath consumes the instruction this cycle.
- instr_o32  output  32  instruction register.
- op_o6  output  6  instr_o32[31:26], to the decoder op input.
- funct_o6  output  6  instr_o32[5:0], to the decoder funct input.
- pc_o32  output  32  PC of the instruction being fetched or held.
- pc_plus4_o32  output  32  pc_o32 + 4, modulo 2^32.
- branch_i  input  1  decoder branch control.
- zero_i  input  1  ALU zero flag.
- jump_i  input  1  decoder jump control.
- retired_o32  output  32  count of accepted instructions.

## Operation
- States:
  - S_REQ: imem_req_o=1. If imem_gnt_i=1, go to S_WAIT.
  - S_WAIT: if imem_rvalid_i=1, capture imem_rdata_i32 into the instruction register and go to S_HOLD.
  - S_HOLD: instr_valid_o=1. If instr_ready_i=1, update the PC, increment retired_o32, and go to S_REQ.
- Only one fetch is outstanding at a time.
  - imem_rvalid_i is ignored outside S_WAIT.
  - imem_gnt_i is ignored outside S_REQ.
- Next PC, evaluated only on an S_HOLD accept. Priority order:
  - jump_i=1: {pc_plus4_o32[31:28], instr_o32[25:0], 2'b00}.
  - else branch_i & zero_i: pc_plus4_o32 + ({{14{instr_o32[15]}}, instr_o32[15:0], 2'b00}), 32-bit wrap.
  - else: pc_plus4_o32.
- Jump takes priority over branch when both are asserted.
- Control inputs are don't-care except in the accept cycle.
- PC addition wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- retired_o32 wraps from 32'hFFFF_FFFF to 0.
- The instruction register, op_o6 and funct_o6 are stable from the cycle after capture until the cycle after acceptance. They retain the last word in S_REQ and S_WAIT, but instr_valid_o=0 there.
- Reset: pc=RESET_PC, state=S_REQ, instr_o32=0, retired_o32=0.
  - While rst_n_i=0, imem_req_o=0 and instr_valid_o=0.
  - Reset asserted in any state, including S_WAIT with a fetch outstanding, wins over every other event that cycle.
  - The instruction memory shares rst_n_i, so no stale response survives reset.

## Timing
- First request: imem_req_o=1 in the first cycle with rst_n_i=1, with imem_addr_o32=RESET_PC.
- Best case: 3 cycles per instruction (gnt in the request cycle, rvalid the next cycle, ready in the first S_HOLD cycle).
  - Each extra cycle of gnt delay, rvalid latency or ready stall adds one cycle.
- The captured word is visible on instr_o32 / op_o6 / funct_o6 with instr_valid_o=1 in the cycle after rvalid.
- The new PC appears on pc_o32 and imem_addr_o32, with imem_req_o=1, in the cycle after the accept.
- retired_o32 increments in the cycle after the accept.
- pc_plus4_o32 is combinational from the PC register.

## Test plan
- Reset then sequential fetch:
  - Stimulus: RESET_PC=0, gnt same cycle, rvalid one cycle later, ready=1, non-branch words.
  - Required: addresses 0,4,8,C at 3-cycle spacing; retired_o32 = 1,2,3,4; op_o6/funct_o6 match each word.
- Taken backward branch:
  - Stimulus: PC=32'h0000_0010, word 32'h1000_FFFE (imm -2), branch_i=1, zero_i=1 at accept.
  - Required: next fetch at 32'h0000_000C.
  - With zero_i=0, the next fetch is at 32'h0000_0014.
- Jump with priority:
  - Stimulus: PC=32'h4000_0100, word 32'h0800_0040, jump_i=1, branch_i=1, zero_i=1.
  - Required: next fetch at 32'h4000_0100.
- Back-pressure and delays:
  - Stimulus: gnt delayed 2 cycles, rvalid 3 cycles after gnt, ready low 4 cycles in S_HOLD.
  - Required: imem_req_o and imem_addr_o32 held throughout the gnt delay; instr_o32 stable and instr_valid_o=1 for all 5 S_HOLD cycles; exactly one increment of retired_o32.
- Spurious handshakes:
  - Stimulus: pulse rvalid in S_REQ and gnt in S_HOLD.
  - Required: no state change, instruction register unchanged.
- Reset mid-fetch and wrap:
  - Stimulus: assert rst_n_i=0 for 1 cycle while in S_WAIT.
  - Required: next cycle shows imem_req_o=1 at RESET_PC with retired_o32=0.
  - Stimulus: PC=32'hFFFF_FFFC, non-branch word, accept.
  - Required: next fetch at 32'h0000_0000.

Source files
------------

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch
//  Brief    : Instruction fetch stage. Owns the PC, fetches one word per
//             instruction over a req/gnt/rvalid port, holds it in an
//             instruction register for the decoder, computes the next PC on
//             accept and counts retired instructions.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    // Must be word aligned (bits [1:0] = 0).
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o32,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i32,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o32,
    output logic [5:0]  op_o6,
    output logic [5:0]  funct_o6,
    output logic [31:0] pc_o32,
    output logic [31:0] pc_plus4_o32,
    input  logic        branch_i,
    input  logic        zero_i,
    input  logic        jump_i,
    output logic [31:0] retired_o32
);

    localparam logic [1:0]  c_S_REQ   = 2'd0;
    localparam logic [1:0]  c_S_WAIT  = 2'd1;
    localparam logic [1:0]  c_S_HOLD  = 2'd2;
    localparam logic [31:0] c_PC_STEP = 32'd4;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_retired;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_jump_target;
    logic [31:0] w_branch_off;
    logic [31:0] w_branch_target;
    logic [31:0] w_next_pc;

    assign w_pc_plus4      = r_pc + c_PC_STEP;
    assign w_jump_target   = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
    assign w_branch_off    = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
    assign w_branch_target = w_pc_plus4 + w_branch_off;

    // Next-PC select: jump beats a taken branch, otherwise fall through.
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (jump_i) begin
            w_next_pc = w_jump_target;
        end else if (branch_i && zero_i) begin
            w_next_pc = w_branch_target;
        end
    end

    // Fetch FSM with PC, instruction register and retire counter.
    // Reset wins over any handshake, including a response arriving in S_WAIT.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state   <= c_S_REQ;
            r_pc      <= RESET_PC;
            r_instr   <= 32'h0000_0000;
            r_retired <= 32'h0000_0000;
        end else begin
            case (r_state)
                c_S_REQ: begin
                    if (imem_gnt_i) begin
                        r_state <= c_S_WAIT;
                    end
                end
                c_S_WAIT: begin
                    if (imem_rvalid_i) begin
                        r_instr <= imem_rdata_i32;
                        r_state <= c_S_HOLD;
                    end
                end
                c_S_HOLD: begin
                    if (instr_ready_i) begin
                        r_pc      <= w_next_pc;
                        r_retired <= r_retired + 32'd1;
                        r_state   <= c_S_REQ;
                    end
                end
                default: begin
                    r_state <= c_S_REQ;
                end
            endcase
        end
    end

    // Handshake outputs are forced low while reset is applied.
    assign imem_req_o    = rst_n_i && (r_state == c_S_REQ);
    assign instr_valid_o = rst_n_i && (r_state == c_S_HOLD);

    assign imem_addr_o32 = r_pc;
    assign pc_o32        = r_pc;
    assign pc_plus4_o32  = w_pc_plus4;
    assign instr_o32     = r_instr;
    assign op_o6         = r_instr[31:26];
    assign funct_o6      = r_instr[5:0];
    assign retired_o32   = r_retired;

endmodule
`default_nettype wire
